// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : fetch_pkg                                            |
// | Description : Shared types and constants for the fetch stage:      |
// |               FSM states, instruction length codes and the bit     |
// |               positions of the opcode length field.                |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package fetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_B1 = 2'd1,
    FETCH_B2 = 2'd2,
    HOLD     = 2'd3
  } fetch_state_t;

  // Instruction length in bytes, encoded directly as the byte count
  localparam logic [1:0] LEN1 = 2'd1;
  localparam logic [1:0] LEN2 = 2'd2;
  localparam logic [1:0] LEN3 = 2'd3;

  // Opcode bits carrying the length field
  localparam int OPC_LEN_MSB = 7;
  localparam int OPC_LEN_LSB = 6;

  // Length field values; 2'b11 is reserved and treated as one byte
  localparam logic [1:0] LFIELD_1B  = 2'b00;
  localparam logic [1:0] LFIELD_2B  = 2'b01;
  localparam logic [1:0] LFIELD_3B  = 2'b10;

  // Default program counter after reset
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_len_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : fetch_len_decode                                     |
// | Description : Combinational opcode -> instruction length decode.   |
// |               Kept standalone so the decoder can reuse it.         |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module fetch_len_decode
  import fetch_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [1:0] o_len
);

  // Map the two-bit length field to a byte count; reserved code is 1 byte
  always_comb begin
    o_len = LEN1;
    case (i_opcode[OPC_LEN_MSB:OPC_LEN_LSB])
      LFIELD_1B: o_len = LEN1;
      LFIELD_2B: o_len = LEN2;
      LFIELD_3B: o_len = LEN3;
      default:   o_len = LEN1;
    endcase
  end

endmodule : fetch_len_decode
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : fetch_unit                                           |
// | Description : Instruction fetch stage. Reads one byte per cycle,   |
// |               assembles 1-3 byte instructions, presents them to    |
// |               the decoder on a valid/ready handshake and accepts   |
// |               branch redirects from execute.                       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_enable,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            instr_opcode,
  output logic [15:0]           instr_operand,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [7:0]            r_opcode;
  logic [15:0]           r_operand;
  logic [ADDR_WIDTH-1:0] r_instr_pc;

  logic [7:0]            w_dec_opcode;
  logic [1:0]            w_len;
  logic                  w_ld_op;
  logic                  w_ld_b1;
  logic                  w_ld_b2;
  logic                  w_pc_inc;

  // In FETCH_OP the opcode is still on the memory bus; afterwards it is latched
  assign w_dec_opcode = (r_state == FETCH_OP) ? mem_read_data[7:0] : r_opcode;

  fetch_len_decode u_len_decode (
    .i_opcode (w_dec_opcode),
    .o_len    (w_len)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH_OP;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath load enables; redirect overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_ld_op     = 1'b0;
    w_ld_b1     = 1'b0;
    w_ld_b2     = 1'b0;
    w_pc_inc    = 1'b0;
    case (r_state)
      FETCH_OP: begin
        if (fetch_enable) begin
          w_ld_op     = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = (w_len == LEN1) ? HOLD : FETCH_B1;
        end
      end
      FETCH_B1: begin
        w_ld_b1     = 1'b1;
        w_pc_inc    = 1'b1;
        w_state_nxt = (w_len == LEN3) ? FETCH_B2 : HOLD;
      end
      FETCH_B2: begin
        w_ld_b2     = 1'b1;
        w_pc_inc    = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (instr_ready) w_state_nxt = FETCH_OP;
      end
      default: w_state_nxt = FETCH_OP;
    endcase
    if (redirect_valid) begin
      w_state_nxt = FETCH_OP;
      w_ld_op     = 1'b0;
      w_ld_b1     = 1'b0;
      w_ld_b2     = 1'b0;
      w_pc_inc    = 1'b0;
    end
  end

  // Program counter: redirect load or modulo-2^ADDR_WIDTH increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= redirect_pc;
    else if (w_pc_inc)       r_pc <= r_pc + ADDR_WIDTH'(1);
  end

  // Instruction assembly; operand is cleared on each new opcode so absent bytes read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode   <= 8'h00;
      r_operand  <= 16'h0000;
      r_instr_pc <= '0;
    end else begin
      if (w_ld_op) begin
        r_opcode   <= mem_read_data[7:0];
        r_operand  <= 16'h0000;
        r_instr_pc <= r_pc;
      end
      if (w_ld_b1) r_operand[7:0]  <= mem_read_data[7:0];
      if (w_ld_b2) r_operand[15:8] <= mem_read_data[7:0];
    end
  end

  // Outputs come straight from registers; valid is simply "in HOLD"
  assign mem_address      = r_pc;
  assign mem_write_enable = 1'b0;
  assign instr_valid      = (r_state == HOLD);
  assign instr_opcode     = r_opcode;
  assign instr_operand    = r_operand;
  assign instr_pc         = r_instr_pc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                        |
// | Description : Directed self-checking bench for fetch_unit with a   |
// |               byte-wide combinational memory model.                |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_enable;
  logic [15:0] mem_address;
  logic [7:0]  mem_read_data;
  logic        mem_write_enable;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic [15:0] instr_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic [7:0]  mem [0:65535];

  int n_pass;
  int n_total;

  fetch_unit #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_enable     (fetch_enable),
    .mem_address      (mem_address),
    .mem_read_data    (mem_read_data),
    .mem_write_enable (mem_write_enable),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_opcode     (instr_opcode),
    .instr_operand    (instr_operand),
    .instr_pc         (instr_pc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
  );

  assign mem_read_data = mem[mem_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge and return on the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0000] = 8'h05;
    mem[16'h0010] = 8'h8A; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
    mem[16'h0020] = 8'h4C; mem[16'h0021] = 8'h7F;
    mem[16'hFFFE] = 8'h80; mem[16'hFFFF] = 8'hCD;
    mem[16'h0030] = 8'h9E; mem[16'h0031] = 8'h55; mem[16'h0032] = 8'h66;
    mem[16'h0040] = 8'hC3;
    mem[16'h0050] = 8'h81; mem[16'h0051] = 8'h11; mem[16'h0052] = 8'h22;

    rst_n = 1'b0; fetch_enable = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid",  32'(instr_valid),      32'h0);
    check("rst_addr",   32'(mem_address),      32'h0000);
    check("rst_opcode", 32'(instr_opcode),     32'h00);
    check("rst_oper",   32'(instr_operand),    32'h0000);
    check("rst_ipc",    32'(instr_pc),         32'h0000);
    check("rst_we",     32'(mem_write_enable), 32'h0);

    // 1-byte instruction one cycle after reset release
    rst_n = 1'b1;
    tick();
    check("t1_valid",  32'(instr_valid),   32'h1);
    check("t1_opcode", 32'(instr_opcode),  32'h05);
    check("t1_oper",   32'(instr_operand), 32'h0000);
    check("t1_ipc",    32'(instr_pc),      32'h0000);
    check("t1_addr",   32'(mem_address),   32'h0001);

    // Redirect coincident with handshake, then 3-byte instruction at 0010
    redirect_to(16'h0010);
    check("t2_rd_valid", 32'(instr_valid), 32'h0);
    check("t2_rd_addr",  32'(mem_address), 32'h0010);
    tick(); tick();
    check("t2_not_yet", 32'(instr_valid), 32'h0);
    tick();
    check("t2_valid",  32'(instr_valid),   32'h1);
    check("t2_opcode", 32'(instr_opcode),  32'h8A);
    check("t2_oper",   32'(instr_operand), 32'h1234);
    check("t2_ipc",    32'(instr_pc),      32'h0010);
    check("t2_addr",   32'(mem_address),   32'h0013);

    // 2-byte instruction held under backpressure (fetch_enable low has no effect)
    instr_ready = 1'b0;
    redirect_to(16'h0020);
    tick(); tick();
    fetch_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_valid",  32'(instr_valid),   32'h1);
      check("t3_opcode", 32'(instr_opcode),  32'h4C);
      check("t3_oper",   32'(instr_operand), 32'h007F);
      check("t3_addr",   32'(mem_address),   32'h0022);
      tick();
    end
    fetch_enable = 1'b1;
    instr_ready = 1'b1;
    tick();
    check("t3_accept_valid", 32'(instr_valid), 32'h0);

    // 3-byte instruction spanning the address wrap
    mem[16'h0000] = 8'hAB;
    redirect_to(16'hFFFE);
    tick(); tick(); tick();
    check("t4_valid",  32'(instr_valid),   32'h1);
    check("t4_opcode", 32'(instr_opcode),  32'h80);
    check("t4_oper",   32'(instr_operand), 32'hABCD);
    check("t4_ipc",    32'(instr_pc),      32'hFFFE);
    check("t4_addr",   32'(mem_address),   32'h0001);

    // Redirect during FETCH_B1 discards the partial instruction
    redirect_to(16'h0030);
    tick();
    check("t5_b1_valid", 32'(instr_valid), 32'h0);
    redirect_to(16'h0040);
    check("t5_rd_valid", 32'(instr_valid), 32'h0);
    check("t5_rd_addr",  32'(mem_address), 32'h0040);
    tick();
    check("t5_valid",  32'(instr_valid),   32'h1);
    check("t5_opcode", 32'(instr_opcode),  32'hC3);
    check("t5_oper",   32'(instr_operand), 32'h0000);
    check("t5_ipc",    32'(instr_pc),      32'h0040);

    // fetch_enable low in FETCH_OP stalls without advancing the pc
    fetch_enable = 1'b0;
    tick();
    check("en_acc_valid", 32'(instr_valid), 32'h0);
    check("en_acc_addr",  32'(mem_address), 32'h0041);
    tick();
    check("en_hold_valid", 32'(instr_valid), 32'h0);
    check("en_hold_addr",  32'(mem_address), 32'h0041);

    // Redirect while disabled still loads the pc
    redirect_to(16'h0050);
    check("en_rd_addr", 32'(mem_address), 32'h0050);
    fetch_enable = 1'b1;

    // Asynchronous reset in the middle of FETCH_B2
    tick(); tick();
    check("t6_b2_addr", 32'(mem_address), 32'h0052);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(instr_valid), 32'h0);
    check("t6_rst_addr",  32'(mem_address), 32'h0000);
    check("t6_rst_ipc",   32'(instr_pc),    32'h0000);
    mem[16'h0000] = 8'h05;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_valid",  32'(instr_valid),  32'h1);
    check("t6_opcode", 32'(instr_opcode), 32'h05);
    check("t6_ipc",    32'(instr_pc),     32'h0000);
    check("t6_addr",   32'(mem_address),  32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Safety net in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_fetch_unit
`default_nettype wire
